nibble_add_sched: RTL and testbench
===================================

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Clock  in  1  rising-edge clock for all state.
REQ-004 Reset  in  1  asynchronous, active-high; clears all state.
REQ-005 Req0  in  1  requester 0 request; held high with stable operands until Gnt0.
REQ-006 A0, B0  in  W each  requester 0 operands.
REQ-007 Cin0  in  1  requester 0 carry-in.
REQ-008 Req1, A1, B1, Cin1  in  1/W/W/1  requester 1 equivalents of Req0, A0, B0, Cin0.
REQ-009 Gnt0, Gnt1  out  1 each  one-cycle grant; operands captured at the rising edge ending the cycle.
REQ-010 Busy  out  1  high whenever the FSM is not IDLE.
REQ-011 Done  out  1  one-cycle pulse; result valid.
REQ-012 Sum  out  W  registered result.
REQ-013 Cout  out  1  registered final carry-out.
REQ-014 Owner  out  1  index of the requester that owns Sum/Cout.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-016 IDLE: if Req0 or Req1 is high, assert exactly one GntN combinationally, capture that requester's A, B, Cin and index, clear the slice counter, go to ADD; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: a lone request wins; with both requests high, the requester not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-018 Gnt0 and Gnt1 SHALL be low outside IDLE and SHALL never be high together.
REQ-019 ADD: each cycle, add captured nibble k of A and B plus the carry register through one 4-bit ripple-carry slice; store the 4-bit result in bits [4k+3:4k] of an internal accumulator; update the carry register; increment k.
REQ-020 The carry register SHALL load the captured Cin at grant.
REQ-021 The datapath SHALL contain exactly one 4-bit adder slice; no wider adder is permitted.
REQ-022 ADD SHALL last exactly NIBBLES cycles (k = 0..NIBBLES-1), least-significant nibble first, then go to DONE.
REQ-023 DONE: load Sum from the accumulator, Cout from the carry register and Owner from the captured index; assert Done for exactly this one cycle; go to IDLE unconditionally.
REQ-024 Sum, Cout and Owner SHALL hold their values until the next DONE.
REQ-025 Timing: if GntN is high in cycle t, ADD occupies cycles t+1..t+NIBBLES, and Done and the new Sum/Cout/Owner appear in cycle t+NIBBLES+1.
REQ-026 Peak throughput SHALL be one operation per NIBBLES+2 cycles; no grant is issued in the DONE cycle.
REQ-027 Requests arriving during ADD or DONE SHALL be ignored (not queued) until IDLE; the requester keeps Req high.
REQ-028 Changes on any A/B/Cin input after capture SHALL NOT affect the operation in flight.
REQ-029 Result SHALL equal (A + B + Cin) mod 2^W, with Cout = bit W of the full sum.

Reset
REQ-030 While Reset is high: state SHALL be IDLE, and Busy, Done, Gnt0, Gnt1, Sum, Cout and Owner SHALL all be 0; the last-granted pointer SHALL be 1, and the accumulator, carry register and slice counter SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no Done pulse; the first request after Reset deasserts SHALL be serviced normally.

Verification
REQ-032 After reset, Req0 with A0=16'h1234, B0=16'h4321, Cin0=0 -> Gnt0 for 1 cycle; Done 5 cycles later; Sum=16'h5555, Cout=0, Owner=0.
REQ-033 Req1 with A1=16'hFFFF, B1=16'h0000, Cin1=1 -> Sum=16'h0000, Cout=1, Owner=1; confirms carry ripples through all 4 slices.
REQ-034 Req0 and Req1 rise together after reset (operands 16'h0001+16'h0001 and 16'h8000+16'h8000) -> Gnt0 first with Sum=16'h0002, Cout=0; then Gnt1 in the cycle after Done, with Sum=16'h0000, Cout=1, Owner=1.
REQ-035 Req0 and Req1 held high for 4 operations -> grant order 0,1,0,1; Gnt never high while Busy; exactly 6 cycles between successive grants.
REQ-036 Reset pulsed in the 2nd ADD cycle -> Busy and outputs return to 0 with no Done; a following Req0 with 16'h00FF+16'h0001, Cin0=0 -> Sum=16'h0100, Cout=0.
REQ-037 Captured operands changed to random values during ADD -> result still matches the operands present at grant; Sum/Cout held stable between Done pulses.

Source files
------------

// File: rtl/nibble_add_sched.sv
// Two-requester W-bit adder that reuses one 4-bit ripple slice over NIBBLES cycles.
// Round-robin grant in IDLE, serial nibble add in ADD, result publish pulse in DONE.
module nibble_add_sched #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] b0_i,
  input  logic         cin0_i,
  input  logic         req1_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b1_i,
  input  logic         cin1_i,
  output logic         gnt0_o,
  output logic         gnt1_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         owner_o
);

  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           carry_q;
  logic           idx_q;
  logic           last_q;
  logic [KW-1:0]  k_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           owner_q;
  logic           busy_q;
  logic           done_q;

  logic           gnt0_c;
  logic           gnt1_c;
  logic [3:0]     nib_a_c;
  logic [3:0]     nib_b_c;
  logic [3:0]     slice_s_c;
  logic           slice_co_c;
  logic [W-1:0]   acc_d;
  logic           k_last_c;

  // Round-robin arbiter: a tie goes to the requester not granted last.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (req0_i && req1_i) begin
        if (last_q) gnt0_c = 1'b1;
        else        gnt1_c = 1'b1;
      end else if (req0_i) begin
        gnt0_c = 1'b1;
      end else if (req1_i) begin
        gnt1_c = 1'b1;
      end
    end
  end

  // Select the captured operand nibble addressed by the slice counter.
  always_comb begin
    nib_a_c = '0;
    nib_b_c = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        nib_a_c = a_q[4*i +: 4];
        nib_b_c = b_q[4*i +: 4];
      end
    end
  end

  // The only adder in the datapath: a 4-bit ripple-carry slice.
  always_comb begin
    logic c;
    c         = carry_q;
    slice_s_c = '0;
    for (int i = 0; i < 4; i++) begin
      slice_s_c[i] = nib_a_c[i] ^ nib_b_c[i] ^ c;
      c            = (nib_a_c[i] & nib_b_c[i]) | (c & (nib_a_c[i] ^ nib_b_c[i]));
    end
    slice_co_c = c;
  end

  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) acc_d[4*i +: 4] = slice_s_c;
    end
  end

  assign k_last_c = (k_q == KW'(NIBBLES - 1));

  // Outputs are loaded on the edge entering DONE so they are visible during DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= 1'b0;
      last_q  <= 1'b1;
      k_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0_c || gnt1_c) begin
            a_q     <= gnt1_c ? a1_i : a0_i;
            b_q     <= gnt1_c ? b1_i : b0_i;
            carry_q <= gnt1_c ? cin1_i : cin0_i;
            idx_q   <= gnt1_c;
            last_q  <= gnt1_c;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          acc_q   <= acc_d;
          carry_q <= slice_co_c;
          k_q     <= k_q + KW'(1);
          if (k_last_c) begin
            sum_q   <= acc_d;
            cout_q  <= slice_co_c;
            owner_q <= idx_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0_o  = gnt0_c;
  assign gnt1_o  = gnt1_c;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Bench for nibble_add_sched: vector table plus arbitration/reset sequences,
// with a negedge monitor feeding a scoreboard of grant-time expected results.
module tb_nibble_add_sched;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, cin0, cin1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0_o, gnt1_o, busy_o, done_o, cout_o, owner_o;
  logic [W-1:0] sum_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int           sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         owner;
    int           gcyc;
  } exp_t;

  exp_t         exp_q[$];
  logic         last_m = 1'b1;
  logic [W-1:0] h_sum  = '0;
  logic         h_cout = 1'b0;
  logic         h_own  = 1'b0;

  nibble_add_sched #(.NIBBLES(N)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req0_i (req0),
    .a0_i   (a0),
    .b0_i   (b0),
    .cin0_i (cin0),
    .req1_i (req1),
    .a1_i   (a1),
    .b1_i   (b1),
    .cin1_i (cin1),
    .gnt0_o (gnt0_o),
    .gnt1_o (gnt1_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .sum_o  (sum_o),
    .cout_o (cout_o),
    .owner_o(owner_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: arbitration model, scoreboard push at grant, pop at Done, output hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_m = 1'b1;
      h_sum  = '0;
      h_cout = 1'b0;
      h_own  = 1'b0;
      chk("rst_gnt", {30'd0, gnt0_o, gnt1_o}, 32'd0);
      chk("rst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
      chk("rst_outputs", {14'd0, cout_o, owner_o, sum_o}, 32'd0);
    end else begin
      chk("gnt_exclusive", {31'd0, gnt0_o & gnt1_o}, 32'd0);
      chk("gnt_while_busy", {31'd0, (gnt0_o | gnt1_o) & busy_o}, 32'd0);
      if (gnt0_o || gnt1_o) begin
        logic         ew;
        logic [W:0]   full;
        exp_t         e;
        ew = (req0 && req1) ? ~last_m : (req0 ? 1'b0 : 1'b1);
        chk("gnt_winner", {31'd0, gnt1_o}, {31'd0, ew});
        last_m = ew;
        if (ew) full = {1'b0, a1} + {1'b0, b1} + (W+1)'(cin1);
        else    full = {1'b0, a0} + {1'b0, b0} + (W+1)'(cin0);
        e.sum   = full[W-1:0];
        e.cout  = full[W];
        e.owner = ew;
        e.gcyc  = cyc;
        exp_q.push_back(e);
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_sum", {16'd0, sum_o}, {16'd0, e.sum});
          chk("sb_cout", {31'd0, cout_o}, {31'd0, e.cout});
          chk("sb_owner", {31'd0, owner_o}, {31'd0, e.owner});
          chk("sb_latency", cyc - e.gcyc, N + 1);
          h_sum  = e.sum;
          h_cout = e.cout;
          h_own  = e.owner;
        end
      end else begin
        chk("output_hold", {14'd0, cout_o, owner_o, sum_o}, {14'd0, h_cout, h_own, h_sum});
      end
    end
  end

  task automatic wait_gnt(input int sel, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((sel == 1) ? gnt1_o : gnt0_o) begin
        ok = 1'b1;
        return;
      end
    end
    fail_now("gnt_timeout");
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        return;
      end
    end
    fail_now("done_timeout");
  endtask

  // One operation; operands of the granted requester are scrambled during ADD.
  task automatic do_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec);
    bit ok;
    @(posedge clk); #1;
    if (sel == 1) begin a1 = a; b1 = b; cin1 = cin; req1 = 1'b1; end
    else          begin a0 = a; b0 = b; cin0 = cin; req0 = 1'b1; end
    wait_gnt(sel, ok);
    @(posedge clk); #1;
    if (sel == 1) begin
      req1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
    end else begin
      req0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
    end
    wait_done(ok);
    if (ok) begin
      chk("vec_sum", {16'd0, sum_o}, {16'd0, es});
      chk("vec_cout", {31'd0, cout_o}, {31'd0, ec});
      chk("vec_owner", {31'd0, owner_o}, sel);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    bit ok;
    int who[4];
    int gc[4];
    int gcount;
    int dcyc;

    vecs[0] = '{0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[4] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    // Reset with a request already pending: no grant may leak out.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
    a0 = 16'hAAAA; b0 = 16'h5555; cin0 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst = 1'b0; req0 = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // Simultaneous requests right after reset: requester 0 wins the tie.
    pulse_reset();
    @(posedge clk); #1;
    a0 = 16'h0001; b0 = 16'h0001; cin0 = 1'b0;
    a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("tie_first_gnt", {30'd0, gnt0_o, gnt1_o}, 32'd2);
    @(posedge clk); #1; req0 = 1'b0;
    wait_done(ok);
    dcyc = cyc;
    chk("tie_sum0", {16'd0, sum_o}, 32'h0002);
    chk("tie_cout0", {31'd0, cout_o}, 32'd0);
    chk("tie_owner0", {31'd0, owner_o}, 32'd0);
    wait_gnt(1, ok);
    chk("tie_gnt1_after_done", cyc, dcyc + 1);
    @(posedge clk); #1; req1 = 1'b0;
    wait_done(ok);
    chk("tie_sum1", {16'd0, sum_o}, 32'h0000);
    chk("tie_cout1", {31'd0, cout_o}, 32'd1);
    chk("tie_owner1", {31'd0, owner_o}, 32'd1);

    // Both requests held: alternating grants at full throughput.
    @(posedge clk); #1;
    a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
    a1 = 16'hAAAA; b1 = 16'h5555; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    gcount = 0;
    for (int n = 0; n < 60 && gcount < 4; n++) begin
      @(negedge clk);
      if (gnt0_o || gnt1_o) begin
        who[gcount] = gnt1_o ? 1 : 0;
        gc[gcount]  = cyc;
        gcount++;
      end
    end
    @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
    chk("rr_grant_count", gcount, 4);
    for (int i = 0; i < gcount; i++) begin
      chk("rr_order", who[i], i % 2);
      if (i > 0) chk("rr_spacing", gc[i] - gc[i-1], N + 2);
    end
    wait_done(ok);

    // Reset in the second ADD cycle abandons the operation silently.
    @(posedge clk); #1;
    a0 = 16'h1357; b0 = 16'h2468; cin0 = 1'b1; req0 = 1'b1;
    wait_gnt(0, ok);
    @(posedge clk); #1; req0 = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    chk("midrst_outputs", {14'd0, cout_o, owner_o, sum_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int n = 0; n < N + 3; n++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done_o}, 32'd0);
    end
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
